piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have no parameters; data width fixed at 8 bits.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port RESET_L  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port DATA_IN  input  8  parallel byte from upstream.
REQ-005 SHALL have port VALID_IN  input  1  upstream has a byte on DATA_IN.
REQ-006 SHALL have port READY_OUT  output  1  block can accept a byte this cycle.
REQ-007 SHALL have port SER_D  output  1  serial bit, drives downstream 1-bit flip-flop D.
REQ-008 SHALL have port SER_EN  output  1  serial bit valid, drives downstream flip-flop EN.
REQ-009 SHALL have port BUSY  output  1  frame in progress.
REQ-010 SHALL have port DONE  output  1  high during final serial cycle of a frame.

Function
REQ-011 SHALL implement FSM states IDLE and SHIFT, plus PARITY when the macro in REQ-024 is defined.
REQ-012 SHALL accept a byte at a rising edge where VALID_IN=1 and READY_OUT=1, latching DATA_IN into an 8-bit shift register and loading bit counter to 0.
REQ-013 SHALL ignore DATA_IN and VALID_IN at every edge where READY_OUT=0; no byte lost or duplicated.
REQ-014 SHALL drive READY_OUT=1 in IDLE, and in SHIFT only when counter=7 with PARITY disabled; READY_OUT=1 in PARITY when enabled; 0 otherwise.
REQ-015 SHALL move IDLE->SHIFT on accept; otherwise SHALL stay in IDLE.
REQ-016 In SHIFT, SHALL drive SER_EN=1, SER_D=shift register bit 0 (LSB first); each edge SHALL shift right one place and increment the counter.
REQ-017 Bit i of a byte accepted at edge k SHALL be on SER_D during the cycle after edge k+i, captured downstream at edge k+i+1.
REQ-018 At counter=7 edge without PARITY: accept (REQ-014) SHALL reload and stay in SHIFT with counter=0 (gapless frames); no accept SHALL go to IDLE.
REQ-019 Outside SHIFT/PARITY, SER_EN=0 and SER_D=0.
REQ-020 BUSY SHALL be 1 in SHIFT and PARITY, 0 in IDLE.
REQ-021 DONE SHALL be combinational, 1 only in the final serial cycle of the frame (SHIFT with counter=7, or PARITY when enabled).
REQ-022 Counter SHALL be 3 bits; never exceeds 7; wraps only by reload.

Reset
REQ-023 RESET_L=0 SHALL immediately (no clock) force IDLE, shift register 0x00, counter 0, READY_OUT=1, SER_D=0, SER_EN=0, BUSY=0, DONE=0; a frame in progress SHALL be abandoned, not resumed; first accept permitted at first rising edge after RESET_L rises.

Configuration
REQ-024 SHALL compile in even-parity bit when PISO_PARITY_EN is defined: after counter=7 edge go to PARITY for one cycle with SER_EN=1, SER_D=XOR of the 8 accepted bits; accept in PARITY SHALL go to SHIFT (counter=0), else IDLE; frame is 9 cycles.
REQ-025 Without PISO_PARITY_EN, SHALL have no PARITY state and no parity logic; frame is 8 cycles; READY_OUT per REQ-014.

Verification
REQ-026 Reset: RESET_L=0 mid-frame, no clock edge -> SER_EN=0, BUSY=0, READY_OUT=1 immediately; after release, 0x3C accepted and sent fresh.
REQ-027 Single byte 0xA5 accepted at edge k -> SER_EN=1 for 8 cycles, SER_D sequence 1,0,1,0,0,1,0,1; DONE high only on 8th; IDLE after.
REQ-028 Back-to-back 0xFF then 0x00, VALID_IN held -> 16 consecutive SER_EN=1 cycles (no parity), SER_D eight 1s then eight 0s, READY_OUT high exactly on cycles 8 and 16.
REQ-029 VALID_IN=1 toggling DATA_IN during SHIFT -> transmitted byte equals DATA_IN at accept edge only.
REQ-030 With PISO_PARITY_EN, 0x07 -> 9 serial cycles, 9th SER_D=1; 0x03 -> 9th SER_D=0; DONE on 9th.
REQ-031 Scoreboard: serial stream captured by downstream 1-bit enabled flip-flop reassembles into accepted bytes, 1000 random bytes with random VALID_IN gaps, zero mismatches.

Source files
------------

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - 8-bit parallel-in serial-out shifter, LSB first, gapless back-to-back frames.
// Optional even-parity trailer bit compiled in with PISO_PARITY_EN.
module piso_serializer (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic [7:0] DATA_IN,
    input  logic       VALID_IN,
    output logic       READY_OUT,
    output logic       SER_D,
    output logic       SER_EN,
    output logic       BUSY,
    output logic       DONE
);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t     state_q;
    state_t     state_d;
    logic [7:0] shreg_q;
    logic [2:0] cnt_q;
    logic       accept;

`ifdef PISO_PARITY_EN
    logic       par_q;
`endif

    assign accept = VALID_IN & READY_OUT;

    always_comb begin
        state_d   = state_q;
        READY_OUT = 1'b0;
        SER_EN    = 1'b0;
        SER_D     = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state_q)
            IDLE: begin
                READY_OUT = 1'b1;
                if (VALID_IN) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                SER_EN = 1'b1;
                SER_D  = shreg_q[0];
                BUSY   = 1'b1;
                if (cnt_q == 3'd7) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    // Last data bit doubles as the reload slot so frames can run gapless.
                    DONE      = 1'b1;
                    READY_OUT = 1'b1;
                    state_d   = VALID_IN ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                SER_EN    = 1'b1;
                SER_D     = par_q;
                BUSY      = 1'b1;
                DONE      = 1'b1;
                READY_OUT = 1'b1;
                state_d   = VALID_IN ? SHIFT : IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= IDLE;
            shreg_q <= 8'h00;
            cnt_q   <= 3'd0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                shreg_q <= DATA_IN;
                cnt_q   <= 3'd0;
`ifdef PISO_PARITY_EN
                par_q   <= ^DATA_IN;
`endif
            end else if (state_q == SHIFT) begin
                shreg_q <= {1'b0, shreg_q[7:1]};
                // Counter saturates at 7; only a reload brings it back to 0.
                if (cnt_q != 3'd7) begin
                    cnt_q <= cnt_q + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed and scoreboard bench for piso_serializer (PISO_PARITY_EN aware).
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       CLK;
    logic       RESET_L;
    logic [7:0] DATA_IN;
    logic       VALID_IN;
    logic       READY_OUT;
    logic       SER_D;
    logic       SER_EN;
    logic       BUSY;
    logic       DONE;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sbq[$];
    logic [7:0] cap;
    int         bitcnt = 0;
    int         n_push = 0;
    int         n_frames = 0;

    piso_serializer dut (
        .CLK       (CLK),
        .RESET_L   (RESET_L),
        .DATA_IN   (DATA_IN),
        .VALID_IN  (VALID_IN),
        .READY_OUT (READY_OUT),
        .SER_D     (SER_D),
        .SER_EN    (SER_EN),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Downstream model: a byte is captured one bit per SER_EN cycle and compared to the accept order.
    always @(negedge CLK) begin
        if (!RESET_L) begin
            bitcnt = 0;
            sbq.delete();
        end else begin
            if (SER_EN) begin
                if (bitcnt < 8) cap[bitcnt] = SER_D;
                else check("sb_parity", {31'd0, SER_D}, {31'd0, ^cap});
                check("sb_done", {31'd0, DONE}, {31'd0, bitcnt == FRAME - 1});
                bitcnt++;
                if (bitcnt == FRAME) begin
                    check("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
                    if (sbq.size() != 0) check("sb_byte", {24'd0, cap}, {24'd0, sbq.pop_front()});
                    n_frames++;
                    bitcnt = 0;
                end
            end
            if (VALID_IN && READY_OUT) begin
                sbq.push_back(DATA_IN);
                n_push++;
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_ser_en"}, {31'd0, SER_EN}, 32'd0);
        check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        check({tag, "_ready"}, {31'd0, READY_OUT}, 32'd1);
        check({tag, "_ser_d"}, {31'd0, SER_D}, 32'd0);
        check({tag, "_done"}, {31'd0, DONE}, 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] b);
        logic exp_d;
        VALID_IN = 1'b1;
        DATA_IN  = b;
        tick;
        VALID_IN = 1'b0;
        for (int j = 0; j < FRAME; j++) begin
            exp_d = (j < 8) ? b[j] : ^b;
            check("frm_ser_en", {31'd0, SER_EN}, 32'd1);
            check("frm_ser_d", {31'd0, SER_D}, {31'd0, exp_d});
            check("frm_done", {31'd0, DONE}, {31'd0, j == FRAME - 1});
            check("frm_busy", {31'd0, BUSY}, 32'd1);
            tick;
        end
        check_idle("frm_end");
    endtask

    initial begin
        logic exp_d;
        int   j;
        int   cyc;
        RESET_L  = 1'b0;
        VALID_IN = 1'b0;
        DATA_IN  = 8'h00;
        #3;
        check_idle("reset");
        tick;
        tick;
        RESET_L = 1'b1;
        tick;

        send_frame(8'hA5);
        tick;

        // Back-to-back 0xFF then 0x00 with VALID_IN held; DATA_IN changes while READY_OUT is low.
        VALID_IN = 1'b1;
        DATA_IN  = 8'hFF;
        tick;
        DATA_IN = 8'h00;
        for (int i = 0; i < 2 * FRAME; i++) begin
            j = i % FRAME;
            exp_d = (j < 8) ? (i < FRAME) : 1'b0;
            check("b2b_ser_en", {31'd0, SER_EN}, 32'd1);
            check("b2b_ser_d", {31'd0, SER_D}, {31'd0, exp_d});
            check("b2b_ready", {31'd0, READY_OUT}, {31'd0, j == FRAME - 1});
            if (i == 2 * FRAME - 1) VALID_IN = 1'b0;
            tick;
        end
        check_idle("b2b_end");

        // Only DATA_IN at the accept edge is transmitted.
        VALID_IN = 1'b1;
        DATA_IN  = 8'h5A;
        tick;
        for (int i = 0; i < FRAME; i++) begin
            exp_d = (i < 8) ? 8'h5A >> i : 1'b0;
            check("hold_ser_d", {31'd0, SER_D}, {31'd0, exp_d});
            DATA_IN = 8'($urandom);
            if (i == FRAME - 1) VALID_IN = 1'b0;
            tick;
        end
        check_idle("hold_end");

        // Asynchronous reset mid-frame, then a fresh frame.
        VALID_IN = 1'b1;
        DATA_IN  = 8'h81;
        tick;
        VALID_IN = 1'b0;
        tick;
        tick;
        check("pre_rst_busy", {31'd0, BUSY}, 32'd1);
        #2;
        RESET_L = 1'b0;
        #1;
        check("rst_ser_en", {31'd0, SER_EN}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_ready", {31'd0, READY_OUT}, 32'd1);
        check("rst_done", {31'd0, DONE}, 32'd0);
        tick;
        RESET_L = 1'b1;
        send_frame(8'h3C);

`ifdef PISO_PARITY_EN
        send_frame(8'h07);
        send_frame(8'h03);
`endif

        // Random traffic with gaps; the negedge scoreboard does the byte comparisons.
        n_push   = 0;
        n_frames = 0;
        cyc      = 0;
        while (n_push < 1000 && cyc < 30000) begin
            VALID_IN = ($urandom_range(0, 3) != 0);
            DATA_IN  = 8'($urandom);
            tick;
            cyc++;
        end
        VALID_IN = 1'b0;
        check("rand_accepts", n_push, 1000);
        cyc = 0;
        while (BUSY && cyc < 40) begin
            tick;
            cyc++;
        end
        check("drain_busy", {31'd0, BUSY}, 32'd0);
        check("sb_pending", sbq.size(), 0);
        check("sb_frames", n_frames, n_push);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
